// File: rtl/conversor_display.sv
// Signed 8-bit to four-position 7-seg code converter.
// Serial shift-and-add-3 BCD conversion with optional leading-zero blanking.
module conversor_display #(
  parameter int SUPRIME_ZEROS = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] valor,
  input  logic       carrega,
  output logic [3:0] digito3,
  output logic [3:0] digito2,
  output logic [3:0] digito1,
  output logic [3:0] digito0,
  output logic       ocupado,
  output logic       pronto
);

  localparam logic [3:0] MENOS  = 4'd10;
  localparam logic [3:0] BRANCO = 4'd11;

  typedef enum logic [1:0] {
    OCIOSO,
    CONVERTE,
    FORMATA
  } estado_t;

  estado_t     estado;
  logic        sinal;
  logic [8:0]  mag;
  logic [11:0] bcd;
  logic [3:0]  cont;

  logic [8:0]  abs_val;
  logic [11:0] bcd_aj;
  logic [11:0] bcd_prox;
  logic [3:0]  f3, f2, f1, f0;
  logic [3:0]  cod_sinal;
  logic [3:0]  cent, dez, uni;
  logic        unused_bits;

  // 9 bits so that -128 yields +128 without overflow
  assign abs_val = valor[7] ? (9'd0 - {valor[7], valor})
                            : {1'b0, valor};

  always_comb begin
    bcd_aj = bcd;
    for (int i = 0; i < 3; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5)
        bcd_aj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
    bcd_prox = {bcd_aj[10:0], mag[7]};
  end

  assign unused_bits = mag[8] ^ bcd_aj[11];

  assign cent = bcd[11:8];
  assign dez  = bcd[7:4];
  assign uni  = bcd[3:0];
  assign cod_sinal = sinal ? MENOS : BRANCO;

  // sign code lands just left of the most significant shown digit
  always_comb begin
    f3 = cod_sinal;
    f2 = cent;
    f1 = dez;
    f0 = uni;
    if (SUPRIME_ZEROS != 0) begin
      if (cent == 4'd0) begin
        f3 = BRANCO;
        if (dez == 4'd0) begin
          f2 = BRANCO;
          f1 = cod_sinal;
        end else begin
          f2 = cod_sinal;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado  <= OCIOSO;
      sinal   <= 1'b0;
      mag     <= '0;
      bcd     <= '0;
      cont    <= '0;
      digito3 <= BRANCO;
      digito2 <= BRANCO;
      digito1 <= BRANCO;
      digito0 <= BRANCO;
      ocupado <= 1'b0;
      pronto  <= 1'b0;
    end else begin
      pronto <= 1'b0;
      unique case (estado)
        OCIOSO: begin
          if (carrega) begin
            sinal   <= valor[7];
            mag     <= abs_val;
            bcd     <= '0;
            cont    <= '0;
            ocupado <= 1'b1;
            estado  <= CONVERTE;
          end
        end
        CONVERTE: begin
          if (cont == 4'd8) begin
            estado <= FORMATA;
          end else begin
            bcd  <= bcd_prox;
            mag  <= {mag[7:0], 1'b0};
            cont <= cont + 4'd1;
          end
        end
        FORMATA: begin
          digito3 <= f3;
          digito2 <= f2;
          digito1 <= f1;
          digito0 <= f0;
          pronto  <= 1'b1;
          ocupado <= 1'b0;
          estado  <= OCIOSO;
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

endmodule
